// File: rtl/l1req_readout_sequencer.sv
// l1req_readout_sequencer: serves Gray-coded L1 request count via req/ack with TMR read pointer
module l1req_readout_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [CNT_W-1:0] i_l1_req_gray,
    input  logic             i_read_ack,
    output logic             o_read_req,
    output logic [CNT_W-1:0] o_read_id,
    output logic [CNT_W-1:0] o_pending,
    output logic             o_busy,
    output logic             o_gray_error,
    output logic             o_overflow,
    output logic             o_seu_error
);
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_gray_sample, r_gray_prev, r_rd0, r_rd1, r_rd2, r_read_id;
    logic             r_primed, r_base, r_gray_error, r_overflow, r_seu_error;
    logic [CNT_W-1:0] w_wr, w_wr_in, w_rd, w_rd_nxt, w_gray_diff;
    logic             w_ack, w_multi;
    function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
        logic [CNT_W-1:0] b;
        b = g;
        for (int i = CNT_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
    assign w_wr        = gray2bin(r_gray_sample);
    assign w_wr_in     = gray2bin(i_l1_req_gray);
    assign w_rd        = (r_rd0 & r_rd1) | (r_rd0 & r_rd2) | (r_rd1 & r_rd2);
    assign w_gray_diff = r_gray_sample ^ r_gray_prev;
    // clearing the lowest set bit leaves something only if more than one bit flipped
    assign w_multi     = |(w_gray_diff & (w_gray_diff - 1'b1));
    assign w_ack       = (r_state == REQ) && i_read_ack;
    // until the baseline is taken the read pointer simply tracks the writer
    assign w_rd_nxt    = r_base ? w_rd + CNT_W'(w_ack) : w_wr;
    assign o_pending    = w_wr - w_rd;
    assign o_busy       = (r_state != IDLE) || (o_pending != '0);
    assign o_read_req   = r_state == REQ;
    assign o_read_id    = r_read_id;
    assign o_gray_error = r_gray_error;
    assign o_overflow   = r_overflow;
    assign o_seu_error  = r_seu_error;
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = (r_base && o_pending != '0) ? REQ : IDLE;
            REQ:     w_state_nxt = i_read_ack ? GAP : REQ;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_gray_sample <= '0;
            r_gray_prev   <= '0;
            r_rd0         <= '0;
            r_rd1         <= '0;
            r_rd2         <= '0;
            r_read_id     <= '0;
            r_primed      <= 1'b0;
            r_base        <= 1'b0;
            r_gray_error  <= 1'b0;
            r_overflow    <= 1'b0;
            r_seu_error   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_gray_sample <= i_l1_req_gray;
            r_gray_prev   <= r_gray_sample;
            r_rd0         <= w_rd_nxt;
            r_rd1         <= w_rd_nxt;
            r_rd2         <= w_rd_nxt;
            r_primed      <= 1'b1;
            r_base        <= r_primed;
            r_seu_error   <= !((r_rd0 == r_rd1) && (r_rd1 == r_rd2));
            if (r_state == IDLE && w_state_nxt == REQ) r_read_id <= w_rd;
            if (r_base && w_multi) r_gray_error <= 1'b1;
            if (r_base && w_wr_in != w_wr && o_pending == '1) r_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_l1req_readout_sequencer.sv
// tb_l1req_readout_sequencer: directed vector table plus hand sequences for multi-cycle corners
module tb_l1req_readout_sequencer;
    logic       clk = 1'b0;
    logic       rst, ack;
    logic [3:0] gray;
    logic       o_read_req, o_busy, o_gray_error, o_overflow, o_seu_error;
    logic [3:0] o_read_id, o_pending;
    int         n_vec = 0;
    int         n_err = 0;
    typedef struct {
        logic       rst;
        logic [3:0] gray;
        logic       ack;
        logic       req;
        logic [3:0] id;
        logic [3:0] pend;
        logic       busy, gerr, ovf, seu;
    } vec_t;
    vec_t vq[$];
    l1req_readout_sequencer #(.CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_l1_req_gray(gray), .i_read_ack(ack),
        .o_read_req(o_read_req), .o_read_id(o_read_id), .o_pending(o_pending),
        .o_busy(o_busy), .o_gray_error(o_gray_error), .o_overflow(o_overflow),
        .o_seu_error(o_seu_error)
    );
    always #5 clk = ~clk;
    function automatic logic [13:0] outs();
        return {o_read_req, o_read_id, o_pending, o_busy, o_gray_error, o_overflow, o_seu_error};
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step(input logic r, input logic [3:0] g, input logic a);
        rst  = r;
        gray = g;
        ack  = a;
        @(posedge clk);
        #1;
    endtask
    task automatic add(input logic r, input logic [3:0] g, input logic a, input logic q,
                       input logic [3:0] id, input logic [3:0] p, input logic b);
        vec_t v;
        v.rst = r; v.gray = g; v.ack = a; v.req = q; v.id = id; v.pend = p; v.busy = b;
        v.gerr = 1'b0; v.ovf = 1'b0; v.seu = 1'b0;
        vq.push_back(v);
    endtask
    task automatic restart();
        step(1'b1, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
    endtask
    initial begin
        logic [3:0] k4;
        add(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        add(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        add(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        add(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        add(1'b0, 4'd1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b1);
        add(1'b0, 4'd1, 1'b0, 1'b1, 4'd0, 4'd1, 1'b1);
        add(1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 4'd1, 1'b1);
        add(1'b0, 4'd3, 1'b0, 1'b0, 4'd0, 4'd1, 1'b1);
        add(1'b0, 4'd2, 1'b0, 1'b1, 4'd1, 4'd2, 1'b1);
        add(1'b0, 4'd2, 1'b1, 1'b0, 4'd1, 4'd1, 1'b1);
        add(1'b0, 4'd2, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1);
        add(1'b0, 4'd2, 1'b0, 1'b1, 4'd2, 4'd1, 1'b1);
        add(1'b0, 4'd2, 1'b1, 1'b0, 4'd2, 4'd0, 1'b1);
        add(1'b0, 4'd2, 1'b0, 1'b0, 4'd2, 4'd0, 1'b0);
        add(1'b0, 4'd2, 1'b1, 1'b0, 4'd2, 4'd0, 1'b0);
        rst = 1'b1; gray = 4'd0; ack = 1'b0;
        #1;
        // quiet link after reset: everything stays low
        step(1'b1, 4'd0, 1'b0);
        chk("reset_outs", 32'(outs()), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'd0, 1'b0);
            chk($sformatf("idle_%0d", i), 32'(outs()), 32'd0);
        end
        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].gray, vq[i].ack);
            chk($sformatf("vec_%0d", i), 32'(outs()),
                32'({vq[i].req, vq[i].id, vq[i].pend, vq[i].busy, vq[i].gerr, vq[i].ovf, vq[i].seu}));
        end
        // overflow: 16 increments never acknowledged
        restart();
        for (int k = 1; k <= 15; k++) begin
            k4 = 4'(k);
            step(1'b0, k4 ^ (k4 >> 1), 1'b0);
        end
        chk("ovf_pend15", 32'(o_pending), 32'd15);
        chk("ovf_not_yet", 32'(o_overflow), 32'd0);
        step(1'b0, 4'd0, 1'b0);
        chk("ovf_outs", 32'(outs()), 32'({1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0}));
        step(1'b0, 4'd0, 1'b0);
        chk("ovf_sticky", 32'(o_overflow), 32'd1);
        // two-bit Gray jump
        restart();
        step(1'b0, 4'd3, 1'b0);
        chk("gerr_delay", 32'(o_gray_error), 32'd0);
        step(1'b0, 4'd3, 1'b0);
        chk("gerr_set", 32'(o_gray_error), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd3, 1'b0);
        chk("gerr_sticky", 32'(o_gray_error), 32'd1);
        step(1'b1, 4'd3, 1'b0);
        chk("gerr_reset", 32'(o_gray_error), 32'd0);
        // upset one read-pointer copy
        restart();
        force dut.r_rd1 = 4'd1;
        step(1'b0, 4'd0, 1'b0);
        chk("seu_set", 32'(o_seu_error), 32'd1);
        chk("seu_pend", 32'(o_pending), 32'd0);
        chk("seu_id", 32'(o_read_id), 32'd0);
        release dut.r_rd1;
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        chk("seu_clear", 32'(o_seu_error), 32'd0);
        chk("seu_pend_after", 32'(o_pending), 32'd0);
        // reset while requesting, writer left at bin 4
        restart();
        step(1'b0, 4'd1, 1'b0);
        step(1'b0, 4'd1, 1'b0);
        chk("pre_reset_req", 32'(o_read_req), 32'd1);
        step(1'b1, 4'b0110, 1'b0);
        chk("mid_reset_outs", 32'(outs()), 32'd0);
        step(1'b0, 4'b0110, 1'b0);
        step(1'b0, 4'b0110, 1'b0);
        step(1'b0, 4'b0110, 1'b0);
        chk("baseline_outs", 32'(outs()), 32'd0);
        step(1'b0, 4'b0111, 1'b0);
        chk("baseline_pend", 32'(o_pending), 32'd1);
        step(1'b0, 4'b0111, 1'b0);
        chk("baseline_serve", 32'({o_read_req, o_read_id}), 32'({1'b1, 4'd4}));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
